// File: rtl/sram_port_arbiter.sv
// Two-requester arbiter for an asynchronous 16-bit SRAM; each 32-bit word is two halfword accesses.
// Optional macro SRAM_ROUND_ROBIN_EN: alternate grants on contention instead of fixed priority to requester 0.
//
// state | meaning
// IDLE  | waiting for a request; grant and operand latch happen here
// LOW   | low halfword access, WAIT cycles
// HIGH  | high halfword access, WAIT cycles
// DONE  | one-cycle ready pulse to the granted requester

module sram_port_arbiter #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 16,
    parameter int WAIT   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [31:0]           addr0,
    input  logic [31:0]           addr1,
    input  logic [2*DATA_W-1:0]   wdata0,
    input  logic [2*DATA_W-1:0]   wdata1,
    output logic [2*DATA_W-1:0]   rdata,
    output logic                  ready0,
    output logic                  ready1,
    inout  wire  [DATA_W-1:0]     sram_dq,
    output logic [ADDR_W-1:0]     sram_addr,
    output logic                  sram_we_n,
    output logic                  sram_oe_n,
    output logic                  sram_ce_n,
    output logic                  sram_ub_n,
    output logic                  sram_lb_n
);

    typedef enum logic [1:0] {ST_IDLE, ST_LOW, ST_HIGH, ST_DONE} state_t;

    localparam logic [3:0] WAIT_M1 = 4'(WAIT - 1);
    localparam logic       WE_PULSE = (WAIT > 1);

    state_t               state;
    logic [3:0]           cnt;
    logic                 grant;
    logic                 op_we;
    logic [ADDR_W-2:0]    op_word;
    logic [2*DATA_W-1:0]  op_wdata;
    logic                 dq_oe;
    logic [DATA_W-1:0]    dq_out;

    logic                 pick1;
    logic                 sel_we;
    logic [31:0]          sel_addr;
    logic [2*DATA_W-1:0]  sel_wdata;

`ifdef SRAM_ROUND_ROBIN_EN
    logic                 last_grant;
`endif

    always_comb begin
        pick1 = 1'b0;
        if (req1 && !req0) begin
            pick1 = 1'b1;
        end
`ifdef SRAM_ROUND_ROBIN_EN
        else if (req0 && req1) begin
            pick1 = !last_grant;
        end
`endif
    end

    assign sel_we    = pick1 ? we1    : we0;
    assign sel_addr  = pick1 ? addr1  : addr0;
    assign sel_wdata = pick1 ? wdata1 : wdata0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= 4'd0;
            grant     <= 1'b0;
            op_we     <= 1'b0;
            op_word   <= '0;
            op_wdata  <= '0;
            rdata     <= '0;
            ready0    <= 1'b0;
            ready1    <= 1'b0;
            sram_addr <= '0;
            sram_we_n <= 1'b1;
            sram_oe_n <= 1'b0;
            dq_oe     <= 1'b0;
            dq_out    <= '0;
`ifdef SRAM_ROUND_ROBIN_EN
            last_grant <= 1'b1;
`endif
        end else begin
            ready0 <= 1'b0;
            ready1 <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req0 || req1) begin
                        grant     <= pick1;
                        op_we     <= sel_we;
                        op_word   <= sel_addr[ADDR_W:2];
                        op_wdata  <= sel_wdata;
`ifdef SRAM_ROUND_ROBIN_EN
                        last_grant <= pick1;
`endif
                        state     <= ST_LOW;
                        cnt       <= WAIT_M1;
                        sram_addr <= {sel_addr[ADDR_W:2], 1'b0};
                        sram_we_n <= !(sel_we && WE_PULSE);
                        sram_oe_n <= sel_we;
                        dq_oe     <= sel_we;
                        dq_out    <= sel_wdata[DATA_W-1:0];
                    end
                end
                ST_LOW: begin
                    if (cnt == 4'd0) begin
                        if (!op_we) begin
                            rdata[DATA_W-1:0] <= sram_dq;
                        end
                        state     <= ST_HIGH;
                        cnt       <= WAIT_M1;
                        sram_addr <= {op_word, 1'b1};
                        sram_we_n <= !(op_we && WE_PULSE);
                        dq_out    <= op_wdata[2*DATA_W-1:DATA_W];
                    end else begin
                        cnt       <= cnt - 4'd1;
                        // release we_n one cycle early so data/address hold past the strobe
                        sram_we_n <= !(op_we && cnt != 4'd1);
                    end
                end
                ST_HIGH: begin
                    if (cnt == 4'd0) begin
                        if (!op_we) begin
                            rdata[2*DATA_W-1:DATA_W] <= sram_dq;
                        end
                        state     <= ST_DONE;
                        sram_we_n <= 1'b1;
                        sram_oe_n <= 1'b0;
                        dq_oe     <= 1'b0;
                        ready0    <= !grant;
                        ready1    <= grant;
                    end else begin
                        cnt       <= cnt - 4'd1;
                        sram_we_n <= !(op_we && cnt != 4'd1);
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign sram_dq   = dq_oe ? dq_out : {DATA_W{1'bz}};
    assign sram_ce_n = 1'b0;
    assign sram_ub_n = 1'b0;
    assign sram_lb_n = 1'b0;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr0[31:ADDR_W+1], addr0[1:0], addr1[31:ADDR_W+1], addr1[1:0]};

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: vector table, corner-case sequences and random traffic against a word-level model.

module tb_sram_port_arbiter;

    localparam int ADDR_W = 18;
    localparam int DATA_W = 16;
    localparam int WAIT   = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
    logic [31:0] rdata;
    logic        ready0, ready1;
    wire  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] mem [64];
    bit          mem_init = 1'b1;
    logic [31:0] model_w [32];
    bit          model_ok [32];
    int          rr_last = 1;

    typedef struct {
        bit          r0, r1, w0, w1;
        logic [31:0] a0, a1, d0, d1;
        int          eg;
        bit          chk;
        logic [31:0] erd;
    } vec_t;

    vec_t tbl [7];

    always #5 clk = ~clk;

    sram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT(WAIT)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .rdata(rdata), .ready0(ready0), .ready1(ready1),
        .sram_dq(sram_dq), .sram_addr(sram_addr),
        .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n), .sram_ce_n(sram_ce_n),
        .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
    );

    function automatic logic [15:0] init_hw(int i);
        return 16'hA500 + 16'(i * 37);
    endfunction

    // external SRAM: drives the bus while output-enabled, stores while write strobe is low
    assign sram_dq = (!sram_oe_n) ? mem[sram_addr[5:0]] : 16'bz;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_hw(i);
        end else if (!sram_we_n) begin
            mem[sram_addr[5:0]] <= sram_dq;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int model_pick(bit r0, bit r1);
        if (r0 && r1) begin
`ifdef SRAM_ROUND_ROBIN_EN
            return (rr_last == 0) ? 1 : 0;
`else
            return 0;
`endif
        end
        return r1 ? 1 : 0;
    endfunction

    task automatic do_reset();
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0; mem_init = 1'b0; rr_last = 1;
    endtask

    task automatic do_access(input bit r0, input bit r1, input bit w0, input bit w1,
                             input logic [31:0] a0, input logic [31:0] a1,
                             input logic [31:0] d0, input logic [31:0] d1,
                             output int g, output logic [31:0] rd);
        int win, p, widx;
        bit we;
        logic [31:0] a, d;
        win  = model_pick(r0, r1);
        we   = (win == 1) ? w1 : w0;
        a    = (win == 1) ? a1 : a0;
        d    = (win == 1) ? d1 : d0;
        widx = int'(a[6:2]);
        req0 = r0; req1 = r1; we0 = w0; we1 = w1;
        addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
        g = -1; rd = '0;
        for (int c = 1; c <= 40 && g < 0; c++) begin
            @(posedge clk); @(negedge clk);
            if (ready0 || ready1) begin
                g  = ready1 ? 1 : 0;
                rd = rdata;
                check("latency", c, 2*WAIT+1);
                check("ready_excl", ready0 & ready1, 0);
            end else if (c <= 2*WAIT) begin
                p = (c > WAIT) ? c - WAIT : c;
                check("phase_addr", sram_addr, {a[ADDR_W:2], (c > WAIT)});
                check("phase_we_n", sram_we_n, !(we && p != WAIT));
                check("phase_oe_n", sram_oe_n, we);
                if (we) check("phase_dq", sram_dq, (c > WAIT) ? d[31:16] : d[15:0]);
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        check("grant", g, win);
        if (g >= 0 && !we && model_ok[widx]) check("rdata", rd, model_w[widx]);
        if (we) begin
            model_w[widx]  = d;
            model_ok[widx] = 1'b1;
        end
        rr_last = win;
        @(posedge clk); #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g, first, second, np, nready, pat;
        logic [31:0] rd, ra0, ra1;
        int gs [4];
        int exp_cont [4];

        for (int i = 0; i < 32; i++) begin
            model_w[i]  = {init_hw(2*i+1), init_hw(2*i)};
            model_ok[i] = 1'b1;
        end

        tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h8, 32'h0, 32'hDEADBEEF, 32'h0, 0, 1'b0, 32'h0};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h8, 32'h0, 32'h0, 1, 1'b1, 32'hDEADBEEF};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h10, 32'h0, 32'h12345678, 1, 1'b0, 32'h0};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h10, 32'h8, 32'h0, 32'h0, 0, 1'b1, 32'h12345678};
`ifdef SRAM_ROUND_ROBIN_EN
        tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h8, 32'h10, 32'h0, 32'h0, 1, 1'b1, 32'h12345678};
        exp_cont = '{0, 1, 0, 1};
`else
        tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h8, 32'h10, 32'h0, 32'h0, 0, 1'b1, 32'hDEADBEEF};
        exp_cont = '{0, 0, 0, 0};
`endif
        tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'hF0000003, 32'h0, 32'h0, 32'h0, 0, 1'b1, 32'hA525A500};
        tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h1C, 32'h0, 32'h0, 1, 1'b1, 32'hA72BA706};

        do_reset();
        @(negedge clk);
        check("rst_ready0", ready0, 0);
        check("rst_ready1", ready1, 0);
        check("rst_we_n", sram_we_n, 1);
        check("rst_oe_n", sram_oe_n, 0);
        check("rst_rdata", rdata, 0);
        check("rst_addr", sram_addr, 0);
        check("rst_dq", sram_dq, mem[sram_addr[5:0]]);
        check("tied_strobes", {sram_ce_n, sram_ub_n, sram_lb_n}, 0);
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) begin
            do_access(tbl[i].r0, tbl[i].r1, tbl[i].w0, tbl[i].w1,
                      tbl[i].a0, tbl[i].a1, tbl[i].d0, tbl[i].d1, g, rd);
            check($sformatf("vec%0d_grant", i), g, tbl[i].eg);
            if (tbl[i].chk) check($sformatf("vec%0d_rdata", i), rd, tbl[i].erd);
        end
        check("sram_hw4", mem[4], 16'hBEEF);
        check("sram_hw5", mem[5], 16'hDEAD);

        // back-to-back: req0 held across ready0
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h8;
        first = -1; second = -1;
        for (int c = 1; c <= 40 && second < 0; c++) begin
            @(posedge clk); @(negedge clk);
            if (ready0) begin
                if (first < 0) first = c;
                else second = c;
            end
        end
        req0 = 1'b0;
        rr_last = 0;
        check("b2b_first", first, 2*WAIT+1);
        check("b2b_gap", second - first, 2*WAIT+2);
        check("b2b_rdata", rdata, 32'hDEADBEEF);
        @(posedge clk); #1;

        // contention held for four accesses
        do_reset();
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0; addr0 = 32'h8; addr1 = 32'h10;
        np = 0;
        gs = '{-1, -1, -1, -1};
        for (int c = 1; c <= 60 && np < 4; c++) begin
            @(posedge clk); @(negedge clk);
            if (ready0 || ready1) begin
                gs[np] = ready1 ? 1 : 0;
                np++;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        check("cont_count", np, 4);
        for (int i = 0; i < 4; i++) check($sformatf("cont_grant%0d", i), gs[i], exp_cont[i]);
        rr_last = exp_cont[3];
        @(posedge clk); #1;

        // reset on the second LOW cycle of a write
        do_reset();
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'h50; wdata0 = 32'h0BADF00D;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_we_n", sram_we_n, 1);
        check("abort_oe_n", sram_oe_n, 0);
        check("abort_ready0", ready0, 0);
        check("abort_addr", sram_addr, 0);
        check("abort_dq", sram_dq, mem[sram_addr[5:0]]);
        rst = 1'b0; req0 = 1'b0; rr_last = 1;
        model_ok[20] = 1'b0;
        nready = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (ready0 || ready1) nready++;
        end
        check("abort_no_ready", nready, 0);
        @(posedge clk); #1;

        // random traffic
        for (int t = 0; t < 80; t++) begin
            pat = int'($urandom_range(1, 3));
            ra0 = (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3)) | ($urandom & 32'hFFF80000);
            ra1 = (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3)) | ($urandom & 32'hFFF80000);
            do_access(pat[0], pat[1], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      ra0, ra1, $urandom, $urandom, g, rd);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
